// File: rtl/btn_sched_pkg.sv
// Shared defaults and event record layout for the button event scheduler.
package btn_sched_pkg;

  localparam int N_BTN_DEF      = 5;
  localparam int ID_W_DEF       = 3;
  localparam int TS_W_DEF       = 16;
  localparam int TICK_DIV_DEF   = 2500000;
  localparam int STABLE_CNT_DEF = 2;
  localparam int FIFO_DEPTH_DEF = 4;

  // Queued event: button index in the MSBs, tick timestamp below it.
  typedef struct packed {
    logic [ID_W_DEF-1:0] id;
    logic [TS_W_DEF-1:0] ts;
  } evt_t;

  localparam int EVT_W_DEF = ID_W_DEF + TS_W_DEF;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/event_fifo.sv
// Synchronous event queue; the write side may accept while full if the head pops in the same cycle.
module event_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full;
  logic             push;
  logic             pop;

  // Handshake: a word moves on push_valid && push_ready or pop_valid && pop_ready.
  always_comb begin
    full       = (count_q == CW'(DEPTH));
    pop_valid  = (count_q != '0);
    pop        = pop_valid && pop_ready;
    push_ready = !full || pop;
    push       = push_valid && push_ready;
    pop_data   = pop_valid ? mem_q[rd_ptr_q] : '0;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/button_event_scheduler.sv
// Debounces all buttons off one shared sample tick and serializes presses into a
// timestamped event queue through a round-robin arbiter.
module button_event_scheduler
  import btn_sched_pkg::*;
#(
  parameter int N_BTN      = N_BTN_DEF,
  parameter int ID_W       = ID_W_DEF,
  parameter int TICK_DIV   = TICK_DIV_DEF,
  parameter int STABLE_CNT = STABLE_CNT_DEF,
  parameter int TS_W       = TS_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [ID_W-1:0]  evt_id,
  output logic [TS_W-1:0]  evt_time,
  output logic             overflow,
  input  logic             overflow_clr
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int SC_W  = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
  localparam int EVT_W = ID_W + TS_W;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [SC_W-1:0]  SC_LAST   = SC_W'(STABLE_CNT - 1);

  logic [N_BTN-1:0] sync1_q, sync2_q;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [TS_W-1:0]  ts_q, ts_d;
  logic [SC_W-1:0]  stab_q [N_BTN];
  logic [SC_W-1:0]  stab_d [N_BTN];
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] level_prev_q;
  logic [N_BTN-1:0] pending_q, pending_d;
  logic [TS_W-1:0]  stamp_q [N_BTN];
  logic [TS_W-1:0]  stamp_d [N_BTN];
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic             overflow_q, overflow_d;

  logic             tick;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] grant_oh;
  logic [N_BTN-1:0] drop;
  logic             grant_found;
  logic [ID_W-1:0]  grant_idx;
  logic             fifo_push_ready;
  logic             push;
  logic [EVT_W-1:0] push_data;
  logic [EVT_W-1:0] head_data;

  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    ts_d       = tick ? ts_q + 1'b1 : ts_q;

    level_d = level_q;
    stab_d  = stab_q;
    if (tick) begin
      for (int i = 0; i < N_BTN; i++) begin
        if (sync2_q[i] != level_q[i]) begin
          if (stab_q[i] == SC_LAST) begin
            level_d[i] = sync2_q[i];
            stab_d[i]  = '0;
          end else begin
            stab_d[i] = stab_q[i] + 1'b1;
          end
        end else begin
          stab_d[i] = '0;
        end
      end
    end

    rise = level_q & ~level_prev_q;

    // First pending index at or after rr_ptr, scanning circularly.
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < N_BTN; k++) begin
      automatic int c = int'(rr_ptr_q) + k;
      if (c >= N_BTN) c = c - N_BTN;
      if (!grant_found && pending_q[c]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(c);
      end
    end
    push      = grant_found && fifo_push_ready;
    push_data = {grant_idx, stamp_q[grant_idx]};
    grant_oh  = '0;
    if (push) grant_oh[grant_idx] = 1'b1;

    // A press on a bit being granted this cycle replaces it rather than being lost.
    drop      = rise & pending_q & ~grant_oh;
    pending_d = (pending_q & ~grant_oh) | rise;
    stamp_d   = stamp_q;
    for (int i = 0; i < N_BTN; i++) begin
      if (rise[i] && !drop[i]) stamp_d[i] = ts_q;
    end

    rr_ptr_d = push ? ID_W'(rr_next(int'(grant_idx), N_BTN)) : rr_ptr_q;

    if (|drop) begin
      overflow_d = 1'b1;
    end else if (overflow_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      tick_cnt_q   <= '0;
      ts_q         <= '0;
      level_q      <= '0;
      level_prev_q <= '0;
      pending_q    <= '0;
      rr_ptr_q     <= '0;
      overflow_q   <= 1'b0;
      for (int i = 0; i < N_BTN; i++) begin
        stab_q[i]  <= '0;
        stamp_q[i] <= '0;
      end
    end else begin
      sync1_q      <= btn_raw;
      sync2_q      <= sync1_q;
      tick_cnt_q   <= tick_cnt_d;
      ts_q         <= ts_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
      pending_q    <= pending_d;
      rr_ptr_q     <= rr_ptr_d;
      overflow_q   <= overflow_d;
      stab_q       <= stab_d;
      stamp_q      <= stamp_d;
    end
  end

  event_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (grant_found),
    .push_ready (fifo_push_ready),
    .push_data  (push_data),
    .pop_valid  (evt_valid),
    .pop_ready  (evt_ready),
    .pop_data   (head_data)
  );

  assign btn_level = level_q;
  assign btn_press = rise;
  assign overflow  = overflow_q;
  assign evt_id    = head_data[EVT_W-1:TS_W];
  assign evt_time  = head_data[TS_W-1:0];

endmodule
